// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Parametrised VGA/VESA raster timing generator. A clock divider produces
//   a one-clk pixel strobe. Horizontal and vertical counters advance on that
//   strobe. Sync, video_on and the line/frame strobes are decoded from the
//   counters.
//
// Ports
//   clk_100MHz  in   system clock
//   reset       in   asynchronous, active-high reset
//   enable      in   tick gate; low freezes the divider and all counters
//   p_tick      out  one-clk pixel strobe (combinational from divider)
//   x, y        out  horizontal / vertical position (CW bits)
//   video_on    out  high inside the active display area
//   hsync       out  horizontal sync, active level HSYNC_POL
//   vsync       out  vertical sync, active level VSYNC_POL
//   line_start  out  one-clk strobe in the first cycle with x == 0
//   frame_start out  one-clk strobe in the first cycle with (x,y) == (0,0)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned CW        = 10
) (
    input  logic          clk_100MHz,
    input  logic          reset,
    input  logic          enable,
    output logic          p_tick,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          video_on,
    output logic          hsync,
    output logic          vsync,
    output logic          line_start,
    output logic          frame_start
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] X_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] Y_LAST   = CW'(V_TOTAL - 1);

    // Region bounds are compared one bit wider than the counters so that a
    // bound equal to 2^CW (e.g. zero back porch with a full-width total)
    // does not wrap to zero.
    localparam logic [CW:0] H_DISP_END = (CW+1)'(H_DISPLAY);
    localparam logic [CW:0] HS_BEGIN   = (CW+1)'(H_DISPLAY + H_FRONT);
    localparam logic [CW:0] HS_END     = (CW+1)'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [CW:0] V_DISP_END = (CW+1)'(V_DISPLAY);
    localparam logic [CW:0] VS_BEGIN   = (CW+1)'(V_DISPLAY + V_FRONT);
    localparam logic [CW:0] VS_END     = (CW+1)'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [DW-1:0] div_q, div_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          video_on_q, video_on_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic          p_tick_s;
    logic [CW:0]   x_ext_s;
    logic [CW:0]   y_ext_s;

    // With CLK_DIV == 1 the divider is stuck at 0 == DIV_LAST, so the tick
    // degenerates to enable.
    assign p_tick_s = enable && (div_q == DIV_LAST);

    // Divider: free-runs only while enabled, so a gap never loses a tick.
    always_comb begin
        div_d = div_q;
        if (enable) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
            end else begin
                div_d = div_q + DW'(1);
            end
        end else begin
            div_d = div_q;
        end
    end

    // Raster counters: x wraps at H_TOTAL and carries into y, y wraps at V_TOTAL.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (p_tick_s) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == Y_LAST) begin
                    y_d = '0;
                end else begin
                    y_d = y_q + CW'(1);
                end
            end else begin
                x_d = x_q + CW'(1);
                y_d = y_q;
            end
        end else begin
            x_d = x_q;
            y_d = y_q;
        end
    end

    // Output decode from the next-count values keeps the registered outputs
    // aligned with the registered x/y they describe.
    always_comb begin
        x_ext_s       = {1'b0, x_d};
        y_ext_s       = {1'b0, y_d};
        video_on_d    = (x_ext_s < H_DISP_END) && (y_ext_s < V_DISP_END);
        hsync_d       = ((x_ext_s >= HS_BEGIN) && (x_ext_s < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d       = ((y_ext_s >= VS_BEGIN) && (y_ext_s < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
        line_start_d  = p_tick_s && (x_d == '0);
        frame_start_d = p_tick_s && (x_d == '0) && (y_d == '0);
    end

    // State registers; reset parks the raster on the last pixel so the first
    // tick lands on (0,0) and raises both strobes.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            div_q         <= '0;
            x_q           <= X_LAST;
            y_q           <= Y_LAST;
            video_on_q    <= 1'b0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            x_q           <= x_d;
            y_q           <= y_d;
            video_on_q    <= video_on_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign p_tick      = p_tick_s;
    assign x           = x_q;
    assign y           = y_q;
    assign video_on    = video_on_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//   Self-checking bench. dut_d runs the default 640x480 / divide-by-4 mode.
//   dut_s runs a tiny 8x6 mode with CLK_DIV=1 and active-high syncs.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // default-mode instance
    logic       rst_d, en_d, pt_d;
    logic [9:0] x_d, y_d;
    logic       von_d, hs_d, vs_d, ls_d, fs_d;

    vga_timing_gen dut_d (
        .clk_100MHz (clk),   .reset      (rst_d), .enable      (en_d),
        .p_tick     (pt_d),  .x          (x_d),   .y           (y_d),
        .video_on   (von_d), .hsync      (hs_d),  .vsync       (vs_d),
        .line_start (ls_d),  .frame_start(fs_d)
    );

    // small-mode instance: H 4/1/2/1, V 3/1/1/1
    logic       rst_s, en_s, pt_s;
    logic [3:0] x_s, y_s;
    logic       von_s, hs_s, vs_s, ls_s, fs_s;

    vga_timing_gen #(
        .CLK_DIV(1), .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CW(4)
    ) dut_s (
        .clk_100MHz (clk),   .reset      (rst_s), .enable      (en_s),
        .p_tick     (pt_s),  .x          (x_s),   .y           (y_s),
        .video_on   (von_s), .hsync      (hs_s),  .vsync       (vs_s),
        .line_start (ls_s),  .frame_start(fs_s)
    );

    typedef struct {
        logic en;
        int   x;
        int   y;
        logic von;
        logic hs;
        logic vs;
        logic ls;
        logic fs;
    } vec_t;

    vec_t tbl [10];

    // reference state for the default instance
    int   md, mx, my, cyc;
    logic mls, mfs;
    // reference state for the small instance
    int   sx, sy;
    logic sls, sfs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // one clock of the default instance, reference model advanced alongside
    task automatic step_d();
        @(posedge clk);
        cyc++;
        mls = 1'b0;
        mfs = 1'b0;
        if (en_d) begin
            if (md == 3) begin
                md = 0;
                if (mx == 799) begin
                    mx = 0;
                    my = (my == 524) ? 0 : my + 1;
                end else begin
                    mx++;
                end
                mls = (mx == 0);
                mfs = (mx == 0) && (my == 0);
            end else begin
                md++;
            end
        end
        #1;
        chk("d_x", x_d, mx);
        chk("d_y", y_d, my);
        chk("d_video_on", von_d, (mx < 640) && (my < 480));
        chk("d_hsync", hs_d, !((mx >= 656) && (mx < 752)));
        chk("d_vsync", vs_d, !((my >= 490) && (my < 492)));
        chk("d_line_start", ls_d, mls);
        chk("d_frame_start", fs_d, mfs);
        chk("d_p_tick", pt_d, en_d && (md == 3));
    endtask

    // one clock of the small instance (tick every enabled clock)
    task automatic step_s();
        @(posedge clk);
        sls = 1'b0;
        sfs = 1'b0;
        if (en_s) begin
            if (sx == 7) begin
                sx = 0;
                sy = (sy == 5) ? 0 : sy + 1;
            end else begin
                sx++;
            end
            sls = (sx == 0);
            sfs = (sx == 0) && (sy == 0);
        end
        #1;
        chk("s_x", x_s, sx);
        chk("s_y", y_s, sy);
        chk("s_video_on", von_s, (sx < 4) && (sy < 3));
        chk("s_hsync", hs_s, (sx >= 5) && (sx < 7));
        chk("s_vsync", vs_s, sy == 4);
        chk("s_line_start", ls_s, sls);
        chk("s_frame_start", fs_s, sfs);
        chk("s_y_range", y_s <= 4'd5, 1'b1);
    endtask

    initial begin
        int first_ls, ls_cyc, ls_cnt, hs_low, von_low, n, fs_cnt, fs_first, fs_last, vs_hi;
        logic found;

        //            en    x  y  von   hs    vs    ls    fs
        tbl[0] = '{1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[1] = '{1'b1, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 2, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 3, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 4, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 4, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 5, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 6, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 7, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9] = '{1'b1, 0, 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        rst_d = 1'b1; en_d = 1'b0;
        rst_s = 1'b1; en_s = 1'b0;
        cyc = 0;
        repeat (3) @(posedge clk);
        #1;

        // ---------------- default mode: reset state ----------------
        chk("d_rst_x", x_d, 799);
        chk("d_rst_y", y_d, 524);
        chk("d_rst_video_on", von_d, 0);
        chk("d_rst_hsync", hs_d, 1);
        chk("d_rst_vsync", vs_d, 1);
        chk("d_rst_line_start", ls_d, 0);
        chk("d_rst_frame_start", fs_d, 0);
        chk("d_rst_p_tick", pt_d, 0);

        // release with enable high: tick visible after the 3rd clk, wrap on the 4th
        @(negedge clk);
        rst_d = 1'b0; en_d = 1'b1;
        md = 0; mx = 799; my = 524;
        repeat (3) step_d();
        chk("d_first_tick", pt_d, 1);
        chk("d_preroll_x", x_d, 799);
        step_d();
        chk("d_wrap_x", x_d, 0);
        chk("d_wrap_y", y_d, 0);
        chk("d_wrap_line_start", ls_d, 1);
        chk("d_wrap_frame_start", fs_d, 1);
        first_ls = cyc;

        // one full line: hsync/video_on shape and line_start period
        ls_cnt = 0; hs_low = 0; von_low = 0; ls_cyc = 0;
        for (int i = 0; i < 3200; i++) begin
            step_d();
            if (hs_d === 1'b0) hs_low++;
            if (von_d === 1'b0) von_low++;
            if (ls_d === 1'b1) begin
                ls_cnt++;
                ls_cyc = cyc;
            end
        end
        chk("d_hsync_low_clks", hs_low, 384);
        chk("d_video_off_clks", von_low, 640);
        chk("d_line_start_count", ls_cnt, 1);
        chk("d_line_period", ls_cyc - first_ls, 3200);
        chk("d_line2_y", y_d, 1);

        // freeze at x=100 with the divider at 2
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            step_d();
            if (mx == 100 && md == 2) found = 1'b1;
        end
        chk("d_reach_x100", found, 1'b1);
        @(negedge clk);
        en_d = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step_d();
            chk("d_freeze_x", x_d, 100);
            chk("d_freeze_tick", pt_d, 0);
            chk("d_freeze_line_start", ls_d, 0);
        end
        @(negedge clk);
        en_d = 1'b1;
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            step_d();
            n++;
            if (x_d !== 10'd100) found = 1'b1;
        end
        chk("d_resume_spacing", n, 2);
        chk("d_resume_x", x_d, 101);

        // asynchronous reset between edges, then identical restart
        #2;
        rst_d = 1'b1;
        #1;
        chk("d_arst_x", x_d, 799);
        chk("d_arst_y", y_d, 524);
        chk("d_arst_hsync", hs_d, 1);
        chk("d_arst_vsync", vs_d, 1);
        chk("d_arst_video_on", von_d, 0);
        @(negedge clk);
        rst_d = 1'b0;
        md = 0; mx = 799; my = 524;
        repeat (3) step_d();
        chk("d_restart_tick", pt_d, 1);
        step_d();
        chk("d_restart_x", x_d, 0);
        chk("d_restart_frame_start", fs_d, 1);
        step_d();
        chk("d_restart_strobe_width", ls_d, 0);
        rst_d = 1'b1;

        // ---------------- small mode ----------------
        #1;
        chk("s_rst_x", x_s, 7);
        chk("s_rst_y", y_s, 5);
        chk("s_rst_hsync", hs_s, 0);
        chk("s_rst_vsync", vs_s, 0);
        chk("s_rst_video_on", von_s, 0);
        @(negedge clk);
        rst_s = 1'b0;
        for (int i = 0; i < 10; i++) begin
            en_s = tbl[i].en;
            @(posedge clk);
            #1;
            chk("v_x", x_s, tbl[i].x);
            chk("v_y", y_s, tbl[i].y);
            chk("v_video_on", von_s, tbl[i].von);
            chk("v_hsync", hs_s, tbl[i].hs);
            chk("v_vsync", vs_s, tbl[i].vs);
            chk("v_line_start", ls_s, tbl[i].ls);
            chk("v_frame_start", fs_s, tbl[i].fs);
            chk("v_p_tick", pt_s, tbl[i].en);
            @(negedge clk);
        end

        // two whole frames from (0,1)
        en_s = 1'b1;
        sx = 0; sy = 1;
        fs_cnt = 0; fs_first = 0; fs_last = 0; vs_hi = 0;
        for (int i = 0; i < 96; i++) begin
            step_s();
            if (vs_s === 1'b1) vs_hi++;
            if (fs_s === 1'b1) begin
                if (fs_cnt == 0) fs_first = i;
                fs_last = i;
                fs_cnt++;
            end
        end
        chk("s_frame_count", fs_cnt, 2);
        chk("s_frame_period", fs_last - fs_first, 48);
        chk("s_vsync_clks", vs_hi, 16);

        // reset mid-frame
        repeat (16) step_s();
        chk("s_mid_y", y_s, 3);
        #2;
        rst_s = 1'b1;
        #1;
        chk("s_arst_x", x_s, 7);
        chk("s_arst_y", y_s, 5);
        chk("s_arst_hsync", hs_s, 0);
        chk("s_arst_vsync", vs_s, 0);
        @(posedge clk);
        #1;
        chk("s_hold_x", x_s, 7);
        @(negedge clk);
        rst_s = 1'b0;
        sx = 7; sy = 5;
        step_s();
        chk("s_restart_x", x_s, 0);
        chk("s_restart_frame_start", fs_s, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
